// File: rtl/motor_passo_monitor.sv
// Receive-side monitor for a 4-bit one-hot stepper coil bus.
// Registers the coil pattern, decodes it into steps, direction and a signed
// position, and reports illegal patterns, skipped phases and stalls.
module motor_passo_monitor #(
  parameter int POS_W     = 16,
  parameter int STALL_CYC = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              sinal,
  input  logic                    clr,
  output logic                    passo,
  output logic                    dir_out,
  output logic signed [POS_W-1:0] posicao,
  output logic                    ativo,
  output logic                    parado,
  output logic                    erro,
  output logic [1:0]              erro_cod
);

  localparam int CNT_W = $clog2(STALL_CYC + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYC);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ATIVO = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    F_NONE    = 2'b00,
    F_ILLEGAL = 2'b01,
    F_SKIP    = 2'b10,
    F_ENTRY   = 2'b11
  } fault_t;

  // Registered state; phases are held as a 2-bit index (0 = phase 1 .. 3 = phase 4)
  // so that modulo-4 neighbour arithmetic is plain 2-bit subtraction.
  logic [3:0]              sinal_q;
  state_t                  state_q, state_d;
  logic [1:0]              fase_q, fase_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    passo_q, passo_d;
  logic                    dir_q, dir_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic                    erro_q, erro_d;
  logic [1:0]              cod_q, cod_d;

  logic       is_phase, is_idle;
  logic [1:0] ph_idx;
  logic [1:0] delta;
  logic       step_fwd, step_rev;
  fault_t     fault;

  // Classify the registered coil pattern as a phase, idle, or illegal.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    is_phase = 1'b0;
    is_idle  = 1'b0;
    ph_idx   = 2'd0;
    case (sinal_q)
      4'b1000: begin is_phase = 1'b1; ph_idx = 2'd0; end
      4'b0100: begin is_phase = 1'b1; ph_idx = 2'd1; end
      4'b0010: begin is_phase = 1'b1; ph_idx = 2'd2; end
      4'b0001: begin is_phase = 1'b1; ph_idx = 2'd3; end
      4'b0000: is_idle = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic: FSM transitions, step decode, stall counter, position, faults.
  always_comb begin
    state_d  = state_q;
    fase_d   = fase_q;
    cnt_d    = cnt_q;
    step_fwd = 1'b0;
    step_rev = 1'b0;
    fault    = F_NONE;
    delta    = ph_idx - fase_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (is_phase) begin
          // Energising on anything but phase 1 means we cannot trust the origin.
          state_d = S_ATIVO;
          fase_d  = ph_idx;
          if (ph_idx != 2'd0) fault = F_ENTRY;
        end else if (!is_idle) begin
          fault = F_ILLEGAL;
        end
      end
      S_ATIVO: begin
        if (is_idle) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!is_phase) begin
          fault = F_ILLEGAL;
        end else begin
          case (delta)
            2'd0: if (cnt_q != STALL_MAX) cnt_d = cnt_q + CNT_W'(1);
            2'd1: begin step_fwd = 1'b1; fase_d = ph_idx; cnt_d = '0; end
            2'd3: begin step_rev = 1'b1; fase_d = ph_idx; cnt_d = '0; end
            default: begin fault = F_SKIP; fase_d = ph_idx; cnt_d = '0; end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    passo_d = step_fwd | step_rev;
    dir_d   = step_fwd ? 1'b1 : (step_rev ? 1'b0 : dir_q);

    // Clear overrides a coincident step for the position only.
    if (clr)           pos_d = '0;
    else if (step_fwd) pos_d = pos_q + POS_W'(1);
    else if (step_rev) pos_d = pos_q - POS_W'(1);
    else               pos_d = pos_q;

    // Sticky flag; the code keeps the first fault since the last clear.
    erro_d = erro_q;
    cod_d  = cod_q;
    if (clr) begin
      erro_d = 1'b0;
      cod_d  = 2'b00;
    end else if (fault != F_NONE) begin
      erro_d = 1'b1;
      if (!erro_q) cod_d = fault;
    end
  end

  // State register with synchronous reset; rst dominates every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      sinal_q <= '0;
      state_q <= S_IDLE;
      fase_q  <= '0;
      cnt_q   <= '0;
      passo_q <= 1'b0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
      erro_q  <= 1'b0;
      cod_q   <= 2'b00;
    end else begin
      sinal_q <= sinal;
      state_q <= state_d;
      fase_q  <= fase_d;
      cnt_q   <= cnt_d;
      passo_q <= passo_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      erro_q  <= erro_d;
      cod_q   <= cod_d;
    end
  end

  assign passo    = passo_q;
  assign dir_out  = dir_q;
  assign posicao  = pos_q;
  assign ativo    = (state_q == S_ATIVO);
  assign parado   = (state_q == S_ATIVO) && (cnt_q == STALL_MAX);
  assign erro     = erro_q;
  assign erro_cod = cod_q;

endmodule

// File: tb/tb_motor_passo_monitor.sv
// Bench for motor_passo_monitor: two instances (default parameters and
// POS_W=4 / STALL_CYC=8) share one stimulus stream and are compared every
// cycle against a behavioural model, plus directed spot values.
module tb_motor_passo_monitor;

  localparam int POS_A = 16, STALL_A = 1000;
  localparam int POS_B = 4,  STALL_B = 8;

  logic clk = 1'b0;
  logic rst, clr;
  logic [3:0] sinal;

  logic passo_a, dir_a, ativo_a, parado_a, erro_a;
  logic [1:0] cod_a;
  logic [POS_A-1:0] pos_a;
  logic passo_b, dir_b, ativo_b, parado_b, erro_b;
  logic [1:0] cod_b;
  logic [POS_B-1:0] pos_b;

  int n_checks = 0, n_pass = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;

  motor_passo_monitor u_a (
    .clk(clk), .rst(rst), .sinal(sinal), .clr(clr),
    .passo(passo_a), .dir_out(dir_a), .posicao(pos_a), .ativo(ativo_a),
    .parado(parado_a), .erro(erro_a), .erro_cod(cod_a)
  );

  motor_passo_monitor #(.POS_W(POS_B), .STALL_CYC(STALL_B)) u_b (
    .clk(clk), .rst(rst), .sinal(sinal), .clr(clr),
    .passo(passo_b), .dir_out(dir_b), .posicao(pos_b), .ativo(ativo_b),
    .parado(parado_b), .erro(erro_b), .erro_cod(cod_b)
  );

  // Behavioural model: phases 1..4, position as a wrapped integer.
  typedef struct {
    bit         act;
    int         fase;
    int         cnt;
    bit         passo;
    bit         dir;
    int         pos;
    bit         erro;
    int         cod;
    logic [3:0] sq;
  } model_t;

  model_t ma, mb;

  function automatic int decode(logic [3:0] s);
    case (s)
      4'b1000: return 1;
      4'b0100: return 2;
      4'b0010: return 3;
      4'b0001: return 4;
      4'b0000: return 0;
      default: return -1;
    endcase
  endfunction

  function automatic model_t model_edge(model_t m, logic [3:0] s, bit c, bit r,
                                        int w, int stall);
    model_t n;
    int ph, step, fault, d, span;
    n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    ph = decode(m.sq);
    step = 0;
    fault = 0;
    if (!m.act) begin
      if (ph == 1) begin n.act = 1; n.fase = 1; n.cnt = 0; end
      else if (ph > 1) begin n.act = 1; n.fase = ph; n.cnt = 0; fault = 3; end
      else if (ph < 0) fault = 1;
    end else if (ph == 0) begin
      n.act = 0;
      n.cnt = 0;
    end else if (ph < 0) begin
      fault = 1;
    end else begin
      d = (ph - m.fase + 4) % 4;
      if (d == 0) n.cnt = (m.cnt < stall) ? m.cnt + 1 : stall;
      else begin
        n.fase = ph;
        n.cnt = 0;
        if (d == 1) begin step = 1; n.dir = 1; end
        else if (d == 3) begin step = -1; n.dir = 0; end
        else fault = 2;
      end
    end
    n.passo = (step != 0);
    span = 1 << w;
    if (c) n.pos = 0;
    else begin
      n.pos = ((m.pos + step) % span + span) % span;
      if (n.pos >= span / 2) n.pos -= span;
    end
    if (c) begin
      n.erro = 0;
      n.cod = 0;
    end else if (fault != 0) begin
      if (!m.erro) n.cod = fault;
      n.erro = 1;
    end
    n.sq = s;
    return n;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("A.passo",  passo_a,  ma.passo);
    check("A.dir",    dir_a,    ma.dir);
    check("A.pos",    $signed(pos_a), ma.pos);
    check("A.ativo",  ativo_a,  ma.act);
    check("A.parado", parado_a, (ma.act && ma.cnt == STALL_A) ? 1 : 0);
    check("A.erro",   erro_a,   ma.erro);
    check("A.cod",    cod_a,    ma.cod);
    check("B.passo",  passo_b,  mb.passo);
    check("B.dir",    dir_b,    mb.dir);
    check("B.pos",    $signed(pos_b), mb.pos);
    check("B.ativo",  ativo_b,  mb.act);
    check("B.parado", parado_b, (mb.act && mb.cnt == STALL_B) ? 1 : 0);
    check("B.erro",   erro_b,   mb.erro);
    check("B.cod",    cod_b,    mb.cod);
  endtask

  // One clock: drive, let the edge happen, advance the model, sample on negedge.
  task automatic do_cycle(input logic [3:0] s, input bit c, input bit r);
    sinal = s;
    clr   = c;
    rst   = r;
    @(posedge clk);
    ma = model_edge(ma, s, c, r, POS_A, STALL_A);
    mb = model_edge(mb, s, c, r, POS_B, STALL_B);
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) do_cycle(s, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] cur;
    int p, r;

    // Reset state
    do_cycle(4'b0000, 1'b0, 1'b1);
    do_cycle(4'b0000, 1'b0, 1'b1);
    check("rst.passo", passo_a, 0);
    check("rst.pos",   pos_a,   0);
    check("rst.ativo", ativo_a, 0);
    check("rst.erro",  erro_a,  0);

    // Forward rotation from idle: four steps
    hold(4'b0000, 4);
    hold(4'b1000, 4);
    check("fwd.ativo", ativo_a, 1);
    hold(4'b0100, 4);
    hold(4'b0010, 4);
    hold(4'b0001, 4);
    hold(4'b1000, 4);
    check("fwd.pos",  $signed(pos_a), 4);
    check("fwd.dir",  dir_a,  1);
    check("fwd.erro", erro_a, 0);

    // Reverse rotation from phase 1: five steps
    do_cycle(4'b1000, 1'b0, 1'b1);
    hold(4'b1000, 3);
    hold(4'b0001, 2);
    hold(4'b0010, 2);
    hold(4'b0100, 2);
    hold(4'b1000, 2);
    hold(4'b0001, 2);
    check("rev.pos_raw", pos_a, 32'h0000_FFFB);
    check("rev.dir",     dir_a, 0);

    // Skipped phase, then illegal pattern, then clear (with a coincident fault)
    hold(4'b1000, 2);
    hold(4'b0010, 2);
    check("skip.erro", erro_a, 1);
    check("skip.cod",  cod_a,  2);
    hold(4'b1100, 2);
    check("illeg.cod", cod_a, 2);
    do_cycle(4'b1100, 1'b1, 1'b0);
    check("clr.erro", erro_a, 0);
    check("clr.cod",  cod_a,  0);
    check("clr.pos",  pos_a,  0);

    // Bad entry from idle
    do_cycle(4'b0000, 1'b0, 1'b1);
    hold(4'b0100, 2);
    check("entry.ativo", ativo_a, 1);
    check("entry.cod",   cod_a,   3);
    check("entry.pos",   pos_a,   0);
    hold(4'b0000, 2);
    check("deenerg.ativo", ativo_a, 0);

    // Stall detection on the STALL_CYC=8 instance
    do_cycle(4'b0000, 1'b0, 1'b1);
    hold(4'b1000, 2);
    check("stall.enter", ativo_b, 1);
    for (int i = 0; i < 7; i++) begin
      hold(4'b1000, 1);
      check("stall.early", parado_b, 0);
    end
    hold(4'b1000, 1);
    check("stall.set", parado_b, 1);
    hold(4'b0100, 2);
    check("stall.step",  passo_b,  1);
    check("stall.clear", parado_b, 0);

    // Position wrap on the 4-bit instance
    do_cycle(4'b0000, 1'b0, 1'b1);
    hold(4'b1000, 2);
    p = 0;
    for (int i = 0; i < 7; i++) begin
      p = (p + 1) % 4;
      cur = 4'b1000 >> p;
      hold(cur, 2);
    end
    check("wrap.pos7", $signed(pos_b), 7);
    p = (p + 1) % 4;
    cur = 4'b1000 >> p;
    hold(cur, 2);
    check("wrap.neg8", $signed(pos_b), -8);

    // Clear on the same cycle as a step
    p = (p + 1) % 4;
    cur = 4'b1000 >> p;
    do_cycle(cur, 1'b0, 1'b0);
    do_cycle(cur, 1'b1, 1'b0);
    check("clrstep.passo", passo_b, 1);
    check("clrstep.pos",   pos_b,   0);

    // Reset mid-sequence
    p = (p + 1) % 4;
    cur = 4'b1000 >> p;
    do_cycle(cur, 1'b0, 1'b0);
    do_cycle(cur, 1'b0, 1'b1);
    check("midrst.passo", passo_b, 0);
    check("midrst.ativo", ativo_b, 0);
    check("midrst.dir",   dir_b,   0);
    check("midrst.pos",   pos_b,   0);

    // Randomised traffic against the model
    p = 0;
    cur = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) ;
      else if (r < 62) begin p = (p + 1) % 4; cur = 4'b1000 >> p; end
      else if (r < 82) begin p = (p + 3) % 4; cur = 4'b1000 >> p; end
      else if (r < 87) begin p = (p + 2) % 4; cur = 4'b1000 >> p; end
      else if (r < 93) cur = 4'b0000;
      else cur = 4'($urandom_range(0, 15));
      do_cycle(cur, ($urandom_range(0, 31) == 0), ($urandom_range(0, 127) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/motor_passo_monitor.md
Name: motor_passo_monitor

Overview:
- Receive-side monitor for the 4-bit one-hot stepper coil bus driven by the motor step controller.
- Decodes the phase sequence into step pulses, direction and a signed absolute position.
- Flags illegal coil patterns, skipped phases and stalls.
- Sits beside the driver, either in loopback or on the coil-driver side, for closed-loop position tracking and fault reporting.

Parameters:
- POS_W, 16, width of the signed position counter (two's complement).
- STALL_CYC, 1000, clock cycles without a phase change before `parado` asserts. Legal range 1..2^20-1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- sinal  input  4  coil phase bus. Legal values:
  - 1000 = phase 1
  - 0100 = phase 2
  - 0010 = phase 3
  - 0001 = phase 4
  - 0000 = de-energized
- clr  input  1  synchronous clear of `posicao`, `erro` and `erro_cod`.
- passo  output  1  one-cycle pulse per decoded step.
- dir_out  output  1  direction of the last decoded step (1 = forward 1→2→3→4→1, 0 = reverse).
- posicao  output  POS_W  signed step count: +1 per forward step, −1 per reverse step.
- ativo  output  1  1 while the coils are energized (FSM in S_ATIVO).
- parado  output  1  1 when energized and no phase change has occurred for STALL_CYC cycles.
- erro  output  1  sticky fault flag.
- erro_cod  output  2  code of the first fault since the last clear:
  - 00 = none
  - 01 = illegal pattern
  - 10 = skipped phase
  - 11 = bad entry from idle

Behaviour:
- Reset (rst=1 at an edge):
  - All outputs go to 0.
  - `sinal_q` = 0000, `fase_ant` = 0, stall counter = 0, FSM = S_IDLE.
  - rst has priority over all other inputs.
- Input stage: `sinal` is registered into `sinal_q` every edge. Decoding is performed on `sinal_q`.
- Decode: `sinal_q` maps to a phase in 1..4, or to idle (0000), or to illegal (any other value).
- Latency:
  - A change on `sinal` sampled at edge N is decoded at edge N+1.
  - `passo`, `posicao` and `dir_out` update at edge N+1 and are visible after that edge.
  - `passo` is high for exactly one cycle.
- FSM S_IDLE:
  - Idle pattern: stay in S_IDLE, `ativo`=0.
  - Phase 1: go to S_ATIVO, set `fase_ant`=1, no step counted (energization only).
  - Phase 2..4: go to S_ATIVO, adopt that phase, no step counted, raise fault 11.
  - Illegal pattern: stay in S_IDLE, raise fault 01.
- FSM S_ATIVO (`ativo`=1), compared against `fase_ant`:
  - Same phase: no step; stall counter increments, saturating at STALL_CYC.
  - `fase_ant`+1 mod 4 (4→1 wraps): passo=1, dir_out=1, posicao+1, counter reset.
  - `fase_ant`−1 mod 4 (1→4 wraps): passo=1, dir_out=0, posicao−1, counter reset.
  - `fase_ant`±2: no step counted; adopt the new phase; raise fault 10; counter reset.
  - Illegal pattern: no step; `fase_ant` held; raise fault 01.
  - Idle pattern: go to S_IDLE, `parado`=0, counter cleared, `posicao` retained.
- Stall detection: `parado`=1 when the stall counter equals STALL_CYC while in S_ATIVO. It clears on the next step or on going idle.
- Fault rules:
  - `erro` is sticky.
  - `erro_cod` latches only the first fault; later faults do not overwrite it.
  - `clr` clears `erro` and `erro_cod` to 0.
  - A fault and `clr` in the same cycle: clr wins, and the fault is dropped.
- Position:
  - Wraps modulo 2^POS_W: +1 from 2^(POS_W−1)−1 gives −2^(POS_W−1), and the reverse on −1.
  - clr sets `posicao`=0. A step in the same cycle is discarded for `posicao`, but `passo` and `dir_out` still update.
- Mid-operation reset: everything returns to reset values on that edge. The first phase seen after reset follows the S_IDLE rules.

Test Plan:
- Reset then sinal sequence 0000,1000,0100,0010,0001,1000, each held 4 cycles → `ativo`=1 after 1000 is decoded; 4 `passo` pulses; dir_out=1; posicao=4; erro=0.
- From phase 1, sinal 0001,0010,0100,1000,0001 → 5 pulses; dir_out=0; posicao=−5 (POS_W=16 reads 16'hFFFB).
- In S_ATIVO at phase 1, drive 0010 → no pulse; erro=1, erro_cod=10. Then drive 1100 → erro_cod stays 10. Then pulse clr → erro=0, erro_cod=00, posicao=0.
- From reset, sinal=0100 → ativo=1, erro_cod=11, posicao=0. Then sinal=0000 → ativo=0.
- STALL_CYC=8: hold 1000 → parado=1 exactly 8 cycles after entering S_ATIVO. Then 0100 → one pulse and parado=0 after that edge.
- POS_W=4: preset 7 forward steps then one more → posicao=−8. Assert clr on the same cycle as a step → posicao=0 while passo=1. Assert rst mid-sequence → all outputs 0 on the next edge.
